baud_counter: RTL and testbench
===============================

# baud_counter

Parametrised baud-rate counter chain for the UART controller, generalising the 4-bit free-running counter into a divisor, oversample and bit counter cascade. It divides the system clock by a runtime divisor to produce an oversample tick. It then counts oversample ticks into bit periods, with a mid-bit sample strobe, and counts bits into frames. It sits between the register interface (divisor, frame length) and the TX/RX shift engines.

## Interface
- DIV_WIDTH, 16: width of the clock divisor.
- OVERSAMPLE, 16: oversample ticks per bit; power of two, ≥ 4.
- FRAME_WIDTH, 4: width of the frame-length input and of the bit counter.
- clk  in  1: single system clock; all state on rising edge.
- reset  in  1: asynchronous, active-high; clears all state and outputs immediately.
- en  in  1: count enable; low holds all counters.
- sync_clr  in  1: synchronous restart of all counters (RX start-bit alignment).
- divisor  in  DIV_WIDTH: clocks per oversample tick; 0 is treated as 1.
- frame_bits  in  FRAME_WIDTH: bits per frame; 0 is treated as 1.
- os_tick  out  1: one-cycle pulse per oversample period.
- mid_tick  out  1: one-cycle pulse at the bit-centre sample point.
- bit_tick  out  1: one-cycle pulse per bit period.
- frame_done  out  1: one-cycle pulse at the end of each frame.
- os_count  out  $clog2(OVERSAMPLE): current oversample index.
- bit_count  out  FRAME_WIDTH: current bit index within the frame.

## Operation
- Internal div_cnt (DIV_WIDTH) and div_reg (latched divisor, effective value max(divisor,1)).
- Oversample event (os_ev): en && !sync_clr && div_cnt == div_reg-1.
  - On os_ev, div_cnt returns to 0.
  - Otherwise, while enabled, div_cnt increments.
- os_count increments on os_ev and wraps OVERSAMPLE-1 → 0.
- bit_count increments on each bit event and wraps effective(frame_bits)-1 → 0.
- Registered pulses (all high only in the cycle after the qualifying edge):
  - os_tick ← os_ev.
  - mid_tick ← os_ev && os_count == OVERSAMPLE/2-1.
  - bit_tick ← os_ev && os_count == OVERSAMPLE-1.
  - frame_done ← bit event && bit_count == effective(frame_bits)-1.
- divisor latching:
  - div_reg loads divisor at reset release, on os_ev, on sync_clr, and every cycle en is low.
  - A mid-period divisor change therefore takes effect at the next period boundary; div_cnt never exceeds div_reg-1.
- frame_bits is sampled directly; software changes it only while en is low.
- en low: div_cnt, os_count and bit_count hold; all pulse outputs are 0 from the next edge.
- sync_clr: has priority over en. Zeroes div_cnt, os_count, bit_count and all pulses on that edge; counting resumes on the following edge if en is high.
- Reset mid-operation: all state and outputs go to 0 asynchronously; no pulse is emitted on release.

## Timing
- Reset values: os_tick, mid_tick, bit_tick, frame_done, os_count, bit_count, div_cnt all 0; div_reg = max(divisor,1).
- With en high from edge 1 and divisor D:
  - the k-th os_tick is high after edge k·D;
  - mid_tick after edge (OVERSAMPLE/2)·D;
  - bit_tick after edges OVERSAMPLE·D·n;
  - frame_done after edge OVERSAMPLE·D·F (F = frame_bits).
- D = 1: os_tick is continuously high while enabled.
- os_tick, mid_tick, bit_tick and frame_done may coincide in the same cycle.
- Latency from os_ev edge to pulse output: 1 cycle (registered). os_count and bit_count update on the same edge as the event.

## Structure
- Shared package uart_pkg holds:
  - OVERSAMPLE default (16), DIV_WIDTH default (16), FRAME_WIDTH default (4);
  - derived OS_W = $clog2(OVERSAMPLE).
- One sub-module, wrap_counter, instantiated three times (divider, oversample, bit):
  - parameter W;
  - ports clk, reset, clr, inc, limit[W-1:0], count, wrap;
  - wrap = inc && count == limit, combinational.
- The top level adds the divisor latch, zero-substitution and output pulse registers.

## Test plan
- Reset and idle:
  - reset high with en=1 → all outputs 0.
  - Release reset with en=0 for 20 cycles → outputs stay 0, os_count=0.
- Basic cascade (D=4, OVERSAMPLE=16, F=10, en=1 from edge 1):
  - os_tick after edges 4, 8, 12, …;
  - mid_tick after edge 32;
  - bit_tick after edges 64 and 128;
  - frame_done after edge 640, then bit_count=0.
- Zero and one divisor: divisor=0 and divisor=1 → os_tick high every cycle; bit_tick every 16 cycles.
- Divisor change mid-period: D=8, switch to D=3 at div_cnt=5 → current period completes at 8 cycles, following periods are 3 cycles.
- sync_clr and enable:
  - sync_clr asserted with os_count=9 and en=1 → next cycle all counters are 0 and no pulse fires; mid_tick follows 8·D cycles later.
  - en low for 10 cycles mid-bit → counts frozen and resume exactly.
- Async reset mid-frame: reset pulsed between edges at bit_count=5 → outputs 0 immediately; after release, frame_done occurs at the full OVERSAMPLE·D·F count.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing defaults used by the baud counter chain.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE  = 32'd16;
  localparam int unsigned UART_DIV_WIDTH   = 32'd16;
  localparam int unsigned UART_FRAME_WIDTH = 32'd4;
  localparam int unsigned UART_OS_W        = $clog2(UART_OVERSAMPLE);

endpackage

// File: rtl/wrap_counter.sv
// Wrapping up-counter: counts inc pulses from 0 to limit, then returns to 0.
// wrap flags the increment that takes the count from limit back to 0.
module wrap_counter #(
  parameter int unsigned W = 32'd4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Terminal-count detect on an incrementing cycle
  always_comb begin
    wrap = inc && (count_q == limit);
  end

  // Next count: clear wins, then wrap to zero, then increment, else hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/baud_counter.sv
// Baud-rate counter chain: clock divider -> oversample counter -> bit counter.
// Produces registered one-cycle pulses for oversample, mid-bit, bit and frame.
module baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = UART_DIV_WIDTH,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned FRAME_WIDTH = UART_FRAME_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sync_clr,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [FRAME_WIDTH-1:0]        frame_bits,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic                          frame_done,
  output logic [$clog2(OVERSAMPLE)-1:0] os_count,
  output logic [FRAME_WIDTH-1:0]        bit_count
);

  // The default build reuses the package width; other oversample rates derive their own.
  localparam int unsigned OS_W = (OVERSAMPLE == UART_OVERSAMPLE) ? UART_OS_W : $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 32'd1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'((OVERSAMPLE / 32'd2) - 32'd1);

  logic [DIV_WIDTH-1:0]   div_in_s;
  logic [DIV_WIDTH-1:0]   div_use_s;
  logic [DIV_WIDTH-1:0]   div_lim_s;
  logic [DIV_WIDTH-1:0]   div_cnt_s;
  logic [DIV_WIDTH-1:0]   div_reg_q;
  logic [DIV_WIDTH-1:0]   div_reg_d;
  logic                   load_pend_q;
  logic                   div_clr_s;
  logic [FRAME_WIDTH-1:0] frame_lim_s;
  logic                   cnt_inc_s;
  logic                   os_ev_s;
  logic                   bit_ev_s;
  logic                   frame_ev_s;
  logic                   mid_ev_s;
  logic [OS_W-1:0]        os_count_s;
  logic [FRAME_WIDTH-1:0] bit_count_s;
  logic                   os_tick_q;
  logic                   mid_tick_q;
  logic                   bit_tick_q;
  logic                   frame_done_q;

  // Zero-substitute the divisor; right after reset the live value stands in for div_reg
  always_comb begin
    if (divisor == '0) begin
      div_in_s = DIV_WIDTH'(1'b1);
    end else begin
      div_in_s = divisor;
    end
    if (load_pend_q) begin
      div_use_s = div_in_s;
    end else begin
      div_use_s = div_reg_q;
    end
    div_lim_s = div_use_s - DIV_WIDTH'(1'b1);
  end

  // Zero-substitute the frame length (0 behaves as a 1-bit frame)
  always_comb begin
    if (frame_bits == '0) begin
      frame_lim_s = '0;
    end else begin
      frame_lim_s = frame_bits - FRAME_WIDTH'(1'b1);
    end
  end

  // Divider advances only when enabled and not being restarted; a count left beyond
  // a divisor lowered while idle is pulled back to zero rather than run to rollover
  always_comb begin
    cnt_inc_s = en && !sync_clr;
    div_clr_s = sync_clr || (div_cnt_s > div_lim_s);
    mid_ev_s  = os_ev_s && (os_count_s == OS_MID);
  end

  // Divisor reload: first edge after reset, while idle, on restart and at each period boundary
  always_comb begin
    if (load_pend_q || !en || sync_clr || os_ev_s) begin
      div_reg_d = div_in_s;
    end else begin
      div_reg_d = div_reg_q;
    end
  end

  // Divisor latch and post-reset load flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg_q   <= DIV_WIDTH'(1'b1);
      load_pend_q <= 1'b1;
    end else begin
      div_reg_q   <= div_reg_d;
      load_pend_q <= 1'b0;
    end
  end

  wrap_counter #(.W(DIV_WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr_s),
    .inc   (cnt_inc_s),
    .limit (div_lim_s),
    .count (div_cnt_s),
    .wrap  (os_ev_s)
  );

  wrap_counter #(.W(OS_W)) u_os (
    .clk   (clk),
    .reset (reset),
    .clr   (sync_clr),
    .inc   (os_ev_s),
    .limit (OS_LAST),
    .count (os_count_s),
    .wrap  (bit_ev_s)
  );

  wrap_counter #(.W(FRAME_WIDTH)) u_bit (
    .clk   (clk),
    .reset (reset),
    .clr   (sync_clr),
    .inc   (bit_ev_s),
    .limit (frame_lim_s),
    .count (bit_count_s),
    .wrap  (frame_ev_s)
  );

  // Output pulse registers: one cycle after the qualifying event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_tick_q    <= 1'b0;
      mid_tick_q   <= 1'b0;
      bit_tick_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      os_tick_q    <= os_ev_s;
      mid_tick_q   <= mid_ev_s;
      bit_tick_q   <= bit_ev_s;
      frame_done_q <= frame_ev_s;
    end
  end

  assign os_tick    = os_tick_q;
  assign mid_tick   = mid_tick_q;
  assign bit_tick   = bit_tick_q;
  assign frame_done = frame_done_q;
  assign os_count   = os_count_s;
  assign bit_count  = bit_count_s;

endmodule

// File: tb/tb_baud_counter.sv
// Directed bench for baud_counter (DIV_WIDTH=16, OVERSAMPLE=16, FRAME_WIDTH=4).
module tb_baud_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        sync_clr;
  logic [15:0] divisor;
  logic [3:0]  frame_bits;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic        frame_done;
  logic [3:0]  os_count;
  logic [3:0]  bit_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  baud_counter #(
    .DIV_WIDTH   (16),
    .OVERSAMPLE  (16),
    .FRAME_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sync_clr   (sync_clr),
    .divisor    (divisor),
    .frame_bits (frame_bits),
    .os_tick    (os_tick),
    .mid_tick   (mid_tick),
    .bit_tick   (bit_tick),
    .frame_done (frame_done),
    .os_count   (os_count),
    .bit_count  (bit_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge, landing on the following falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_os"},    32'(os_tick),    32'd0);
    check_val({tag, "_mid"},   32'(mid_tick),   32'd0);
    check_val({tag, "_bit"},   32'(bit_tick),   32'd0);
    check_val({tag, "_frame"}, 32'(frame_done), 32'd0);
    check_val({tag, "_oscnt"}, 32'(os_count),   32'd0);
    check_val({tag, "_bitcnt"},32'(bit_count),  32'd0);
  endtask

  // Checks enabled edges k0+1 .. k0+n against the closed-form schedule for divisor d, frame f.
  task automatic run_check(input string tag, input int d, input int f, input int k0, input int n);
    int p;
    p = 16 * d;
    for (int i = 1; i <= n; i++) begin
      int k;
      k = k0 + i;
      cyc();
      check_val({tag, "_os"},    32'(os_tick),    32'((k % d) == 0));
      check_val({tag, "_mid"},   32'(mid_tick),   32'((k % p) == (p / 2)));
      check_val({tag, "_bit"},   32'(bit_tick),   32'((k % p) == 0));
      check_val({tag, "_frame"}, 32'(frame_done), 32'((k % (p * f)) == 0));
      check_val({tag, "_oscnt"}, 32'(os_count),   (k / d) % 16);
      check_val({tag, "_bitcnt"},32'(bit_count),  (k / p) % f);
    end
  endtask

  // Disabled restart with a new divisor/frame length; caller raises en afterwards.
  task automatic restart(input string tag, input logic [15:0] d, input logic [3:0] f);
    en         = 1'b0;
    sync_clr   = 1'b1;
    divisor    = d;
    frame_bits = f;
    cyc();
    check_idle(tag);
    sync_clr = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b1;
    sync_clr   = 1'b0;
    divisor    = 16'd4;
    frame_bits = 4'd10;
    repeat (3) cyc();
    check_idle("rst");

    // Reset release with counting disabled
    reset = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_idle("idle");
    end

    // Basic cascade D=4, F=10: frame ends at edge 640
    en = 1'b1;
    run_check("casc", 4, 10, 0, 640);
    en      = 1'b0;
    divisor = 16'd0;
    cyc();
    check_idle("stop");

    // Divisor 0 behaves as 1
    en = 1'b1;
    run_check("div0", 1, 10, 0, 40);

    // Divisor 1
    restart("clr1", 16'd1, 4'd10);
    en = 1'b1;
    run_check("div1", 1, 10, 0, 40);

    // frame_bits 0 behaves as a single-bit frame
    restart("clr2", 16'd1, 4'd0);
    en = 1'b1;
    run_check("f0", 1, 1, 0, 40);

    // Divisor 8 -> 3 after edge 5: ticks at 8, 11, 14
    restart("clr3", 16'd8, 4'd10);
    en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      check_val("dchg_os", 32'(os_tick), 32'((k == 8) || (k == 11) || (k == 14)));
      if (k == 5) divisor = 16'd3;
    end
    check_val("dchg_oscnt", 32'(os_count), 32'd3);

    // sync_clr at os_count=9, on an edge that would have ticked
    restart("clr4", 16'd2, 4'd10);
    en = 1'b1;
    run_check("pre", 2, 10, 0, 19);
    sync_clr = 1'b1;
    cyc();
    check_idle("sclr");
    sync_clr = 1'b0;
    run_check("post", 2, 10, 0, 40);

    // Freeze for 10 cycles mid-bit, then resume in phase
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_val("frz_os",     32'(os_tick),    32'd0);
      check_val("frz_mid",    32'(mid_tick),   32'd0);
      check_val("frz_bit",    32'(bit_tick),   32'd0);
      check_val("frz_frame",  32'(frame_done), 32'd0);
      check_val("frz_oscnt",  32'(os_count),   32'd4);
      check_val("frz_bitcnt", 32'(bit_count),  32'd1);
    end
    en = 1'b1;
    run_check("resume", 2, 10, 40, 60);

    // Asynchronous reset between edges at bit_count=5
    restart("clr5", 16'd3, 4'd10);
    en = 1'b1;
    run_check("prer", 3, 10, 0, 247);
    #2 reset = 1'b1;
    #1 check_idle("arst");
    @(negedge clk);
    reset = 1'b0;
    run_check("postr", 3, 10, 0, 480);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
